// File: rtl/rs232c_io.sv
// rs232c_io: byte/word I/O dispatcher between the execute stage and UART FIFOs.
// One FIFO access per byte with a gap cycle; stalls the CPU until done.
module rs232c_io #(
    parameter int BYTES = 4,
    localparam int DW = 8 * BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_valid,
    input  logic [31:0]   inst,
    input  logic [DW-1:0] rt,
    output logic          stall,
    output logic          push_send_data,
    output logic [7:0]    send_data,
    input  logic          tx_full,
    input  logic          rx_wait,
    input  logic [7:0]    received_data,
    output logic          rx_pop,
    output logic          enable,
    output logic          float,
    output logic [4:0]    addr,
    output logic [DW-1:0] data
);

    localparam logic [5:0] INPUTW  = 6'b111100;
    localparam logic [5:0] INPUTB  = 6'b111101;
    localparam logic [5:0] OUTPUTB = 6'b111110;
    localparam logic [5:0] OUTPUTW = 6'b111111;

    typedef enum logic [2:0] {
        IDLE,
        RX_POLL,
        RX_GAP,
        WB,
        TX_POLL,
        TX_GAP
    } state_t;

    state_t state, state_nxt;

    logic [5:0]    op;
    logic          is_rx;
    logic          is_tx;
    logic          is_word;
    logic          accept;
    logic          last;
    logic [3:0]    idx;
    logic [3:0]    cnt;
    logic [4:0]    rd_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] asm_q;
    logic [7:0]    tx_byte;
    logic          unused_inst;

    assign op          = inst[31:26];
    assign is_rx       = (op == INPUTB) | (op == INPUTW);
    assign is_tx       = (op == OUTPUTB) | (op == OUTPUTW);
    assign is_word     = (op == INPUTW) | (op == OUTPUTW);
    assign accept      = inst_valid & (is_rx | is_tx) & (state == IDLE);
    assign last        = (idx == cnt - 4'd1);
    assign unused_inst = ^{inst[25:21], inst[15:0]};

    // Select the operand byte addressed by the current byte index.
    always_comb begin
        tx_byte = rt_q[7:0];
        for (int b = 0; b < BYTES; b++) begin
            if (idx == b[3:0]) begin
                tx_byte = rt_q[8*b +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: poll, then a gap cycle so FIFO flags can settle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_rx ? RX_POLL : TX_POLL;
                end
            end
            RX_POLL: begin
                if (!rx_wait) begin
                    state_nxt = RX_GAP;
                end
            end
            RX_GAP: begin
                state_nxt = last ? WB : RX_POLL;
            end
            WB: begin
                state_nxt = IDLE;
            end
            TX_POLL: begin
                if (!tx_full) begin
                    state_nxt = TX_GAP;
                end
            end
            TX_GAP: begin
                state_nxt = last ? IDLE : TX_POLL;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered strobes, operand latches and little-endian byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_send_data <= 1'b0;
            send_data      <= 8'h00;
            rx_pop         <= 1'b0;
            enable         <= 1'b0;
            addr           <= 5'd0;
            data           <= '0;
            idx            <= 4'd0;
            cnt            <= 4'd1;
            rd_q           <= 5'd0;
            rt_q           <= '0;
            asm_q          <= '0;
        end else begin
            push_send_data <= 1'b0;
            rx_pop         <= 1'b0;
            enable         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q  <= inst[20:16];
                        rt_q  <= rt;
                        cnt   <= is_word ? 4'(BYTES) : 4'd1;
                        idx   <= 4'd0;
                        asm_q <= '0;
                    end
                end
                RX_POLL: begin
                    if (!rx_wait) begin
                        rx_pop <= 1'b1;
                        for (int b = 0; b < BYTES; b++) begin
                            if (idx == b[3:0]) begin
                                asm_q[8*b +: 8] <= received_data;
                            end
                        end
                    end
                end
                RX_GAP: begin
                    idx <= idx + 4'd1;
                    if (last) begin
                        enable <= 1'b1;
                        addr   <= rd_q;
                        data   <= asm_q;
                    end
                end
                TX_POLL: begin
                    if (!tx_full) begin
                        push_send_data <= 1'b1;
                        send_data      <= tx_byte;
                    end
                end
                TX_GAP: begin
                    idx <= idx + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Stall covers the accept cycle combinationally, then every busy cycle.
    always_comb begin
        stall = (state != IDLE) | accept;
        float = 1'b0;
    end

endmodule

// File: tb/tb_rs232c_io.sv
// tb_rs232c_io: scoreboard bench for rs232c_io with BYTES=4.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_rs232c_io;

    localparam logic [5:0] INPUTW  = 6'b111100;
    localparam logic [5:0] INPUTB  = 6'b111101;
    localparam logic [5:0] OUTPUTB = 6'b111110;
    localparam logic [5:0] OUTPUTW = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] rt;
    logic        stall;
    logic        push_send_data;
    logic [7:0]  send_data;
    logic        tx_full;
    logic        rx_wait;
    logic [7:0]  received_data;
    logic        rx_pop;
    logic        enable;
    logic        float;
    logic [4:0]  addr;
    logic [31:0] data;

    rs232c_io #(.BYTES(4)) dut (
        .clk(clk),
        .rst(rst),
        .inst_valid(inst_valid),
        .inst(inst),
        .rt(rt),
        .stall(stall),
        .push_send_data(push_send_data),
        .send_data(send_data),
        .tx_full(tx_full),
        .rx_wait(rx_wait),
        .received_data(received_data),
        .rx_pop(rx_pop),
        .enable(enable),
        .float(float),
        .addr(addr),
        .data(data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          pops;
    } wb_t;

    wb_t        wbq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int pushes   = 0;
    logic prev_push = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: pops on the edge that ends an rx_pop cycle.
    always @(posedge clk) begin
        if (rx_pop) begin
            pops++;
            if (rxq.size() > 0) void'(rxq.pop_front());
        end
        if (push_send_data) pushes++;
    end

    // RX FIFO flags update away from the active edge.
    always @(negedge clk) begin
        rx_wait = (rxq.size() == 0);
        if (rxq.size() > 0) received_data = rxq[0];
        else received_data = 8'h00;
    end

    // Monitor: compare every strobe against the scoreboard.
    always @(negedge clk) begin
        if (enable) begin
            if (wbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb actual=%0h required=none", data);
            end else begin
                wb_t e;
                e = wbq.pop_front();
                chk("wb_addr", 64'(addr), 64'(e.a));
                chk("wb_data", 64'(data), 64'(e.d));
                chk("wb_pops", 64'(pops), 64'(e.pops));
            end
            chk("en_pop_excl", 64'(rx_pop), 64'd0);
        end
        if (push_send_data) begin
            if (txq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_push actual=%0h required=none",
                         send_data);
            end else begin
                chk("tx_byte", 64'(send_data), 64'(txq.pop_front()));
            end
            chk("push_gap", 64'(prev_push), 64'd0);
        end
        prev_push = push_send_data;
    end

    task automatic issue(input logic [5:0] op, input logic [4:0] rd,
                         input logic [31:0] rtv, input logic exp_stall);
        @(negedge clk);
        inst_valid = 1'b1;
        inst       = {op, 5'd0, rd, 16'd0};
        rt         = rtv;
        #1;
        chk("stall_accept", 64'(stall), 64'(exp_stall));
        @(negedge clk);
        inst_valid = 1'b0;
        inst       = 32'd0;
    endtask

    task automatic wait_idle(input string name, input int lim,
                             output int n);
        n = 0;
        #1;
        while (stall && n < lim) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (stall) begin
            failures++;
            $display("FAIL %s_timeout actual=stall required=idle", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = 32'd0;
        rt         = 32'd0;
        tx_full    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_push", 64'(push_send_data), 64'd0);
        chk("rst_sdata", 64'(send_data), 64'd0);
        chk("rst_pop", 64'(rx_pop), 64'd0);
        chk("rst_en", 64'(enable), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_float", 64'(float), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // INPUTB rd=5, RX holds 0xA7
        rxq.push_back(8'hA7);
        wbq.push_back('{5'd5, 32'h0000_00A7, pops + 1});
        issue(INPUTB, 5'd5, 32'd0, 1'b1);
        wait_idle("inputb", 20, n);
        chk("inputb_latency", 64'(n), 64'd3);

        // INPUTW with 3-cycle gaps between arriving bytes
        wbq.push_back('{5'd9, 32'h4433_2211, pops + 4});
        issue(INPUTW, 5'd9, 32'd0, 1'b1);
        begin
            logic [7:0] bytes [4];
            bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
            for (int k = 0; k < 4; k++) begin
                repeat (3) @(negedge clk);
                rxq.push_back(bytes[k]);
            end
        end
        wait_idle("inputw", 60, n);

        // OUTPUTW with a 5-cycle TX-full pause before byte 2
        txq.push_back(8'hEF);
        txq.push_back(8'hBE);
        txq.push_back(8'hAD);
        txq.push_back(8'hDE);
        base = pushes;
        issue(OUTPUTW, 5'd0, 32'hDEAD_BEEF, 1'b1);
        n = 0;
        while (pushes != base + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("outw_two_pushes", 64'(pushes - base), 64'd2);
        tx_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("outw_stall_hold", 64'(stall), 64'd1);
            chk("outw_no_push", 64'(push_send_data), 64'd0);
        end
        tx_full = 1'b0;
        wait_idle("outputw", 30, n);
        chk("outw_pushes", 64'(pushes - base), 64'd4);

        // OUTPUTB rt=0x1234: one push, idle in 2 cycles
        txq.push_back(8'h34);
        base = pops;
        issue(OUTPUTB, 5'd2, 32'h0000_1234, 1'b1);
        wait_idle("outputb", 20, n);
        chk("outb_latency", 64'(n), 64'd2);
        chk("outb_no_pop", 64'(pops - base), 64'd0);

        // Reset during the 3rd byte of INPUTW
        rxq.push_back(8'h01);
        rxq.push_back(8'h02);
        rxq.push_back(8'h03);
        rxq.push_back(8'h04);
        base = pops;
        issue(INPUTW, 5'd3, 32'd0, 1'b1);
        n = 0;
        while (pops != base + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_two_pops", 64'(pops - base), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_pop", 64'(rx_pop), 64'd0);
        chk("abort_en", 64'(enable), 64'd0);
        chk("abort_data", 64'(data), 64'd0);
        chk("abort_addr", 64'(addr), 64'd0);
        chk("abort_push", 64'(push_send_data), 64'd0);
        chk("abort_sdata", 64'(send_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        repeat (2) @(negedge clk);
        rxq.push_back(8'h5A);
        wbq.push_back('{5'd7, 32'h0000_005A, pops + 1});
        issue(INPUTB, 5'd7, 32'd0, 1'b1);
        wait_idle("post_abort", 20, n);
        chk("post_abort_latency", 64'(n), 64'd3);

        // Non-I/O op is ignored
        issue(6'b000000, 5'd1, 32'hFFFF_FFFF, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("nonio_stall", 64'(stall), 64'd0);
        end

        // inst_valid during a busy transfer is ignored
        base = pushes;
        wbq.push_back('{5'd12, 32'h0000_003C, pops + 1});
        issue(INPUTB, 5'd12, 32'd0, 1'b1);
        @(negedge clk);
        inst_valid = 1'b1;
        inst       = {OUTPUTB, 5'd0, 5'd4, 16'd0};
        rt         = 32'h0000_00FF;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("busy_stall", 64'(stall), 64'd1);
        end
        inst_valid = 1'b0;
        inst       = 32'd0;
        rxq.push_back(8'h3C);
        wait_idle("busy", 20, n);
        chk("busy_no_push", 64'(pushes - base), 64'd0);

        repeat (3) @(negedge clk);
        chk("wbq_drained", 64'(wbq.size()), 64'd0);
        chk("txq_drained", 64'(txq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs232c_io.md
# rs232c_io

Parametrised successor to the RS232C instruction dispatcher, sitting between the CPU execute stage and the UART TX/RX FIFOs. It decodes byte I/O (INPUTB/OUTPUTB) and multi-byte word I/O (INPUTW/OUTPUTW). It sequences one FIFO access per byte, respects TX-full backpressure, and stalls the CPU until the transfer completes. Received bytes are assembled little-endian and written back to the register file through the same enable/addr/data port.

## Interface
- BYTES, 4: bytes per word transfer (1..8); DW = 8*BYTES.
- INPUTB, 6'b111101: opcode, receive 1 byte, zero-extended to DW.
- OUTPUTB, 6'b111110: opcode, send rt[7:0].
- INPUTW, 6'b111100: opcode, receive BYTES bytes.
- OUTPUTW, 6'b111111: opcode, send rt[DW-1:0], BYTES bytes.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_valid  in  1  inst is issued this cycle.
- inst  in  32  instruction; op = inst[31:26], rd = inst[20:16].
- rt  in  DW  source operand, sampled at accept.
- stall  out  1  CPU must hold; combinational.
- push_send_data  out  1  one-cycle TX FIFO push strobe.
- send_data  out  8  byte pushed.
- tx_full  in  1  TX FIFO cannot accept a push.
- rx_wait  in  1  RX FIFO empty; when 0, received_data is head byte.
- received_data  in  8  RX FIFO head.
- rx_pop  out  1  one-cycle RX FIFO pop strobe.
- enable  out  1  register writeback strobe.
- float  out  1  constant 0.
- addr  out  5  writeback register.
- data  out  DW  writeback value.

## Operation
- States: IDLE, RX_POLL, RX_GAP, WB, TX_POLL, TX_GAP.
- Accept in IDLE when inst_valid=1 and op is one of the four opcodes; latch rd, rt, byte count N (1 for *B, BYTES for *W), index i=0. Other ops are ignored.
- stall = (state != IDLE) | (inst_valid & op is I/O & state == IDLE).
- RX_POLL: if rx_wait=0, set rx_pop<=1 and capture received_data into byte i of the assembly register, then go to RX_GAP. Otherwise stay; no timeout.
- RX_GAP: rx_pop<=0 and i<=i+1. If i==N-1, go to WB with enable<=1, addr<=rd, data<=assembly (upper bytes 0 for INPUTB). Otherwise go to RX_POLL.
- WB: enable<=0, go to IDLE.
- TX_POLL: if tx_full=0, set push_send_data<=1 and send_data<=rt byte i, then go to TX_GAP.
- TX_GAP: push<=0 and i<=i+1. If i==N-1, go to IDLE; otherwise go to TX_POLL.
- The gap cycle lets FIFO flags update; there are never back-to-back strobes.
- Byte order: LSB first, for both directions.
- The assembly register is cleared at accept, so stale bytes never leak.
- inst_valid while not IDLE is ignored.

## Timing
- Reset: state=IDLE; push_send_data, send_data, rx_pop, enable, addr, data, i = 0. float=0 always.
- Reset mid-transfer aborts immediately, with no writeback. Bytes already popped are lost; bytes already pushed stay sent.
- INPUTB with data present, accepted at edge 0:
  - rx_pop is high in cycle 1–2.
  - enable is high in cycle 2–3.
  - stall is high from the accept cycle through cycle 2–3; IDLE after edge 3.
- INPUTW with all bytes present: enable rises 2*BYTES edges after accept. OUTPUTW with TX not full: last push ends 2*BYTES edges after accept.
- Strobes are registered, one cycle wide. enable is never concurrent with rx_pop.
- rx_wait or tx_full deasserting mid-word resumes at the next byte, with no reordering.

## Test plan
- INPUTB, rd=5, RX holds 0xA7 -> one rx_pop; enable for 1 cycle with addr=5, data=0x000000A7; stall low after WB.
- INPUTW (BYTES=4), RX bytes 0x11,0x22,0x33,0x44 arriving with 3-cycle gaps -> 4 pops, data=0x44332211, no enable before the 4th byte.
- OUTPUTW with rt=0xDEADBEEF, tx_full forced high for 5 cycles before byte 2 -> pushes 0xEF,0xBE, pause, then 0xAD,0xDE; stall held throughout.
- OUTPUTB with rt=0x1234 -> single push of 0x34; no enable; idle in 2 cycles.
- rst pulsed during the 3rd byte of INPUTW -> all outputs 0 at once, no enable, next INPUTB works normally.
- Non-I/O op with inst_valid=1, and inst_valid during a busy transfer -> no strobes, no state change, stall unaffected.
